xoodyak_tag_check: RTL and testbench



---
 rtl/xoodyak_tag_check.sv | 205 ++++++++++++++++++++
 tb/tb_xoodyak_tag_check.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xoodyak_tag_check.sv
// xoodyak_tag_check: constant-time comparison of a computed Xoodyak tag
// against a received reference tag.
//
// The computed tag arrives byte-serially from the duplex core (no
// backpressure) and is buffered. The reference tag is pulled through a
// ready/valid handshake, one byte at a time, as soon as the matching
// computed byte is in the buffer. Every byte of the tag is always
// consumed, whether or not an earlier byte mismatched, so the time to the
// result does not depend on where the tags differ.
//
// Optional feature: define XOODYAK_TAG_TIMEOUT_EN to abort a check that
// sees TIMEOUT_CYCLES consecutive cycles without progress. When it is
// undefined, no timeout logic is built and a stalled check waits forever.

module xoodyak_tag_check #(
    parameter int MAX_TAG_BYTES  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] tag_len,
    input  logic [7:0] squeeze_data,
    input  logic       squeeze_valid,
    input  logic [7:0] ref_data,
    input  logic       ref_valid,
    output logic       ref_ready,
    output logic       busy,
    output logic       done,
    output logic       tag_ok,
    output logic       err
);

    // Buffer address width; pointers stay 5 bits, only the low bits index.
    localparam int         AW      = (MAX_TAG_BYTES > 1) ? $clog2(MAX_TAG_BYTES) : 1;
    localparam logic [5:0] MAX_LEN = 6'(MAX_TAG_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] len_q, len_d;
    logic [4:0] wr_ptr_q, wr_ptr_d;
    logic [4:0] rd_ptr_q, rd_ptr_d;
    logic [7:0] diff_q, diff_d;
    logic       err_q, err_d;
    logic       tag_ok_q, tag_ok_d;

    // Computed-tag byte buffer.
    logic [7:0] tag_buf [MAX_TAG_BYTES];
    logic       buf_wr;

    logic       len_valid;
    logic       sq_fire;
    logic       ref_fire;
    logic [7:0] rd_byte;
    logic [7:0] diff_upd;

`ifdef XOODYAK_TAG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
`endif

    // Outputs decoded from registered state only.
    assign busy      = (state_q == ST_COLLECT);
    assign done      = (state_q == ST_DONE);
    assign ref_ready = (state_q == ST_COLLECT) && (rd_ptr_q < wr_ptr_q);
    assign tag_ok    = tag_ok_q;
    assign err       = err_q;

    // Reference byte is compared against the buffered computed byte.
    assign rd_byte  = tag_buf[rd_ptr_q[AW-1:0]];
    assign diff_upd = diff_q | (rd_byte ^ ref_data);

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no
        // path through the case can leave one unassigned and infer a latch.
        state_d   = state_q;
        len_d     = len_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        diff_d    = diff_q;
        err_d     = err_q;
        tag_ok_d  = tag_ok_q;
        buf_wr    = 1'b0;
        sq_fire   = 1'b0;
        ref_fire  = 1'b0;
        len_valid = (tag_len != 5'd0) && ({1'b0, tag_len} <= MAX_LEN);
`ifdef XOODYAK_TAG_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Accepted start: clear the previous result and pointers.
                    wr_ptr_d = 5'd0;
                    rd_ptr_d = 5'd0;
                    diff_d   = 8'd0;
                    tag_ok_d = 1'b0;
`ifdef XOODYAK_TAG_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                    if (len_valid) begin
                        len_d   = tag_len;
                        err_d   = 1'b0;
                        state_d = ST_COLLECT;
                    end else begin
                        // Impossible length: report an error immediately.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_COLLECT: begin
                sq_fire  = squeeze_valid && (wr_ptr_q < len_q);
                ref_fire = ref_valid && ref_ready;

                if (sq_fire) begin
                    buf_wr   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 5'd1;
                end else if (squeeze_valid) begin
                    // More computed bytes than the tag holds: overflow.
                    err_d = 1'b1;
                end

                if (ref_fire) begin
                    diff_d   = diff_upd;
                    rd_ptr_d = rd_ptr_q + 5'd1;
                    if (rd_ptr_d == len_q) begin
                        state_d  = ST_DONE;
                        tag_ok_d = (diff_upd == 8'd0) && !err_d;
                    end
                end

`ifdef XOODYAK_TAG_TIMEOUT_EN
                // Count consecutive cycles with neither a write nor a read.
                if (sq_fire || ref_fire) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                    if (idle_cnt_d == CW'(TIMEOUT_CYCLES)) begin
                        state_d  = ST_DONE;
                        err_d    = 1'b1;
                        tag_ok_d = 1'b0;
                    end
                end
`endif
            end

            ST_DONE: begin
                // Result is presented for exactly one cycle.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q  <= ST_IDLE;
            len_q    <= 5'd0;
            wr_ptr_q <= 5'd0;
            rd_ptr_q <= 5'd0;
            diff_q   <= 8'd0;
            err_q    <= 1'b0;
            tag_ok_q <= 1'b0;
`ifdef XOODYAK_TAG_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            diff_q   <= diff_d;
            err_q    <= err_d;
            tag_ok_q <= tag_ok_d;
`ifdef XOODYAK_TAG_TIMEOUT_EN
            idle_cnt_q <= idle_cnt_d;
`endif
        end
    end

    // Tag buffer write port.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is deliberately not reset; a byte is only ever
        // read after it was written in the same check.
        if (buf_wr) begin
            tag_buf[wr_ptr_q[AW-1:0]] <= squeeze_data;
        end
    end

endmodule

// File: tb/tb_xoodyak_tag_check.sv
// Self-checking bench for xoodyak_tag_check: directed scenarios plus
// randomized checks, compared every cycle against a transaction-level
// model built from queues of tag bytes.
`timescale 1ns/1ps

module tb_xoodyak_tag_check;

    localparam int MAX = 16;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] tag_len;
    logic [7:0] squeeze_data;
    logic       squeeze_valid;
    logic [7:0] ref_data;
    logic       ref_valid;
    logic       ref_ready;
    logic       busy;
    logic       done;
    logic       tag_ok;
    logic       err;

    always #5 clk = ~clk;

    xoodyak_tag_check #(
        .MAX_TAG_BYTES (MAX),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .tag_len      (tag_len),
        .squeeze_data (squeeze_data),
        .squeeze_valid(squeeze_valid),
        .ref_data     (ref_data),
        .ref_valid    (ref_valid),
        .ref_ready    (ref_ready),
        .busy         (busy),
        .done         (done),
        .tag_ok       (tag_ok),
        .err          (err)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_COLLECT, M_DONE} mphase_t;
    mphase_t     m_phase = M_IDLE;
    bit          m_valid = 1'b0;
    int          m_len   = 0;
    byte unsigned m_sq[$];   // computed bytes received in this check
    int          m_nref  = 0; // reference bytes consumed so far
    bit          m_mism  = 1'b0;
    bit          m_err   = 1'b0;
    bit          m_ok    = 1'b0;
    int          m_idle  = 0;
    bit          m_hs    = 1'b0; // a reference byte was taken at the last edge

    always @(posedge clk) begin : model
        bit wrote;
        m_hs = 1'b0;
        if (rst) begin
            m_valid = 1'b1;
            m_phase = M_IDLE;
            m_sq.delete();
            m_nref = 0; m_mism = 0; m_err = 0; m_ok = 0; m_idle = 0;
        end else if (m_valid) begin
            case (m_phase)
                M_IDLE: if (start) begin
                    m_sq.delete();
                    m_nref = 0; m_mism = 0; m_ok = 0; m_err = 0; m_idle = 0;
                    if (tag_len == 0 || int'(tag_len) > MAX) begin
                        m_err   = 1'b1;
                        m_phase = M_DONE;
                    end else begin
                        m_len   = int'(tag_len);
                        m_phase = M_COLLECT;
                    end
                end
                M_COLLECT: begin
                    m_hs  = ref_valid && (m_nref < m_sq.size());
                    wrote = squeeze_valid && (m_sq.size() < m_len);
                    if (m_hs) begin
                        if (m_sq[m_nref] != ref_data) m_mism = 1'b1;
                        m_nref++;
                    end
                    if (wrote) m_sq.push_back(squeeze_data);
                    else if (squeeze_valid) m_err = 1'b1;
                    if (m_hs && m_nref == m_len) begin
                        m_phase = M_DONE;
                        m_ok    = !m_mism && !m_err;
                    end
`ifdef XOODYAK_TAG_TIMEOUT_EN
                    else if (wrote || m_hs) m_idle = 0;
                    else begin
                        m_idle++;
                        if (m_idle == TMO) begin
                            m_phase = M_DONE;
                            m_err   = 1'b1;
                            m_ok    = 1'b0;
                        end
                    end
`endif
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("busy",      busy,      m_phase == M_COLLECT);
            check("done",      done,      m_phase == M_DONE);
            check("ref_ready", ref_ready, (m_phase == M_COLLECT) && (m_nref < m_sq.size()));
            check("tag_ok",    tag_ok,    m_ok);
            check("err",       err,       m_err);
        end
    end

    // ---------------- stimulus ----------------
    byte unsigned sq_b[32];
    byte unsigned ref_b[32];

    task automatic idle_inputs();
        start = 1'b0; tag_len = 5'd0;
        squeeze_valid = 1'b0; squeeze_data = 8'd0;
        ref_valid = 1'b0; ref_data = 8'd0;
    endtask

    task automatic run_check(input string name, input int len, input int n_sq, input int n_ref,
                             input int p_sq, input int p_ref, input int sq_delay, input int ref_delay,
                             input bit stray_start, input bit exp_ok, input bit exp_err);
        int si, ri, cyc;
        bit sv, rv;
        si = 0; ri = 0; cyc = 0;
        @(posedge clk); #1;
        start = 1'b1; tag_len = 5'(len);
        @(posedge clk); #1;
        start = 1'b0;
        while (m_phase != M_DONE && cyc < 400) begin
            sv = (si < n_sq) && (cyc >= sq_delay) && ($urandom_range(99) < p_sq);
            rv = (ri < n_ref) && (cyc >= ref_delay) && ($urandom_range(99) < p_ref);
            squeeze_valid = sv;
            squeeze_data  = sv ? sq_b[si] : 8'($urandom);
            ref_valid     = rv;
            ref_data      = rv ? ref_b[ri] : 8'($urandom);
            start         = stray_start && ($urandom_range(7) == 0);
            tag_len       = 5'($urandom);
            @(posedge clk); #1;
            if (sv) si++;
            if (rv && m_hs) ri++;
            cyc++;
        end
        idle_inputs();
        check({name, " done"},   done,   1'b1);
        check({name, " tag_ok"}, tag_ok, exp_ok);
        check({name, " err"},    err,    exp_err);
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc, len, idx;
        bit ok;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset busy",      busy,      1'b0);
        check("reset done",      done,      1'b0);
        check("reset ref_ready", ref_ready, 1'b0);
        check("reset tag_ok",    tag_ok,    1'b0);
        check("reset err",       err,       1'b0);

        // Four matching A5 bytes.
        for (int i = 0; i < 4; i++) begin sq_b[i] = 8'hA5; ref_b[i] = 8'hA5; end
        run_check("match4", 4, 4, 4, 100, 100, 0, 0, 1'b0, 1'b1, 1'b0);

        // Sixteen bytes, first reference byte corrupted.
        for (int i = 0; i < 16; i++) begin sq_b[i] = 8'(i); ref_b[i] = 8'(i); end
        ref_b[0] = 8'hFF;
        run_check("mism16", 16, 16, 16, 70, 70, 0, 0, 1'b1, 1'b0, 1'b0);

        // Reference valid held before any computed byte.
        for (int i = 0; i < 8; i++) begin sq_b[i] = 8'(8'h30 + i); ref_b[i] = 8'(8'h30 + i); end
        run_check("refearly8", 8, 8, 8, 100, 100, 5, 0, 1'b0, 1'b1, 1'b0);

        // Overflow: five computed bytes into a four-byte tag.
        for (int i = 0; i < 5; i++) begin sq_b[i] = 8'(8'h50 + i); ref_b[i] = 8'(8'h50 + i); end
        run_check("overflow", 4, 5, 4, 100, 100, 0, 8, 1'b0, 1'b0, 1'b1);

        // Illegal lengths.
        run_check("len0",  0,  0, 0, 100, 100, 0, 0, 1'b0, 1'b0, 1'b1);
        run_check("len17", 17, 0, 0, 100, 100, 0, 0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a check, then a fresh two-byte check.
        @(posedge clk); #1;
        start = 1'b1; tag_len = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        squeeze_valid = 1'b1; squeeze_data = 8'h11;
        @(posedge clk); #1;
        squeeze_data = 8'h22; ref_valid = 1'b1; ref_data = 8'h11;
        @(posedge clk); #1;
        squeeze_valid = 1'b0; ref_data = 8'h22;
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        sq_b[0] = 8'hC3; sq_b[1] = 8'h3C; ref_b[0] = 8'hC3; ref_b[1] = 8'h3C;
        run_check("after_abort", 2, 2, 2, 100, 100, 0, 0, 1'b0, 1'b1, 1'b0);

        // Stalled check: no input after start.
        @(posedge clk); #1;
        start = 1'b1; tag_len = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
`ifdef XOODYAK_TAG_TIMEOUT_EN
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("timeout latency", 32'(cyc), 32'd16);
        check("timeout err",     err,      1'b1);
        check("timeout tag_ok",  tag_ok,   1'b0);
        @(posedge clk); #1;
`else
        repeat (40) @(posedge clk);
        #1;
        check("stall busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`endif

        // Randomized checks with stray starts while busy.
        for (int r = 0; r < 24; r++) begin
            len = $urandom_range(MAX, 1);
            for (int i = 0; i < len; i++) begin
                sq_b[i]  = 8'($urandom);
                ref_b[i] = sq_b[i];
            end
            if ($urandom_range(1) == 1) begin
                idx = $urandom_range(len - 1);
                ref_b[idx] = ref_b[idx] ^ 8'($urandom_range(255, 1));
            end
            ok = 1'b1;
            for (int i = 0; i < len; i++) if (ref_b[i] != sq_b[i]) ok = 1'b0;
            run_check("random", len, len, len, $urandom_range(100, 60), $urandom_range(100, 60),
                      0, 0, 1'b1, ok, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
